load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised multi-cycle load/store unit; successor to the single-cycle load-only datapath.
- Sits between the decode/regfile stage and data memory.
- Supports byte, half, word and unsigned loads, and byte, half and word stores; XLEN=64 adds doubleword and unsigned-word accesses.
- Features not in the load-only path: byte enables, misalignment and illegal-op detection, a ready/ack memory handshake with wait states and timeout, and a valid/ready response.

Parameters:
- XLEN, 32: data width; only 32 or 64 allowed; BE_W = XLEN/8.
- TIMEOUT, 16: maximum ACCESS cycles without mem_ack before aborting; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_base  in  XLEN  rs1 value.
- req_offset  in  XLEN  sign-extended immediate.
- req_wdata  in  XLEN  rs2 value (stores).
- req_rd  in  5  destination register tag.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  XLEN  effective address with the low log2(BE_W) bits cleared.
- mem_be  out  BE_W  byte enables.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_ack  in  1  memory done; mem_rdata is valid in the same cycle.
- mem_rdata  in  XLEN  read data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  XLEN  extended load data; 0 for stores and errors.
- rsp_rd  out  5  latched req_rd.
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low: when rst=0 at a clk rising edge, state becomes IDLE, wait counter = 0, and all registered outputs = 0. req_ready = 0 while rst = 0.
- Reset mid-operation: the transaction is abandoned. mem_req is low after that edge and no response is produced.
- Effective address: ea = req_base + req_offset, modulo 2^XLEN; carry-out is ignored.
- Size decode:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - XLEN=64 only: 011 D, 110 WU.
  - Anything else is illegal: 111 always; 011/110 when XLEN=32; 100/101/110 for stores.
- Misalignment: H/HU with ea[0]=1; W/WU with ea[1:0]≠0; D with ea[2:0]≠0. Illegal funct3 takes priority over misalignment.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch rd, we, size, ea and wdata.
  - Error → RESP with the error code; no memory access is made.
  - Otherwise → ACCESS.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are registered and held stable until ack.
  - Byte enables: B: 1<<off; H: 0b11<<off; W: 0xF<<off; D: all ones; off = ea[log2(BE_W)-1:0].
  - Store data: wdata low bits shifted left by 8·off.
  - Wait counter increments each cycle without ack.
  - mem_ack → capture the response, mem_req=0, → RESP. For loads, extract (mem_rdata >> 8·off), then sign-extend (B/H/W) or zero-extend (BU/HU/WU).
  - Counter reaching TIMEOUT-1 with no ack → rsp_err=11, mem_req=0, → RESP. A late mem_ack after that is ignored.
- RESP:
  - rsp_valid=1 with data, rd and err held until rsp_ready; then → IDLE.
  - rsp_ready may be held high in advance; the handshake still costs one RESP cycle.
- Latency: request accepted at edge N; mem_req high in cycle N+1; ack in cycle N+1 gives rsp_valid in cycle N+2. Best-case throughput is one transaction per 3 cycles. An error request gives rsp_valid in cycle N+1.
- No simultaneous accept and response: req_ready is low outside IDLE.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - state enum {IDLE, ACCESS, RESP};
  - error codes ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT.
- Sub-module lsu_lane_align: purely combinational; produces be and shifted wdata from (size, off, wdata), and the extended load value from (size, unsigned, off, rdata). Reused by the load path.

Test Plan:
1. LW, base=0x100, offset=4, mem_rdata=0xDEADBEEF, ack in first cycle: mem_addr=0x104, mem_be=1111; rsp_data=0xDEADBEEF, rsp_err=00, in cycle N+2.
2. LB then LBU at ea=0x103, mem_rdata=0x80FF_0000:
   - LB: mem_be=1000, rsp_data=0xFFFFFF80.
   - LBU: rsp_data=0x00000080.
3. SH at ea=0x202, req_wdata=0x1234ABCD: mem_we=1, mem_addr=0x200, mem_be=1100, mem_wdata[31:16]=0xABCD; rsp_data=0.
4. LW at ea=0x101: rsp_err=01 in cycle N+1, mem_req never asserts. funct3=111: rsp_err=10.
5. Stalls:
   - mem_ack withheld for 5 cycles: mem_addr/mem_be stay stable and the response is correct.
   - mem_ack never given, TIMEOUT=16: rsp_err=11 after 16 ACCESS cycles and mem_req drops.
6. Reset and backpressure:
   - rst=0 during ACCESS: next cycle mem_req=0 and rsp_valid=0; after release, a fresh LW completes normally.
   - rsp_ready held low for 3 cycles: rsp fields stay stable and req_ready stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, codes and decode helpers for the load/store unit.
package lsu_pkg;

   // RISC-V funct3 size/sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Access size, equal to funct3[1:0]; funct3[2] is the unsigned flag
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Response error codes
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   // Illegal funct3: 111 always, D/WU without 64-bit data, unsigned codes on stores
   function automatic logic f3_is_illegal(input logic [2:0] f3, input logic we, input int xlen);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = we;
         F3_D:             bad = (xlen != 64);
         F3_WU:            bad = we || (xlen != 64);
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Natural-alignment check on the low effective-address bits
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] ea_lo);
      logic mis;
      case (size)
         SZ_H:    mis = ea_lo[0];
         SZ_W:    mis = (ea_lo[1:0] != 2'b00);
         SZ_D:    mis = (ea_lo != 3'b000);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request, memory and response signals of the load/store unit.
interface lsu_if #(parameter int XLEN = 32);
   localparam int BE_W = XLEN / 8;

   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_base;
   logic [XLEN-1:0] req_offset;
   logic [XLEN-1:0] req_wdata;
   logic [4:0]      req_rd;
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [BE_W-1:0] mem_be;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic [4:0]      rsp_rd;
   logic [1:0]      rsp_err;

   // The unit itself
   modport slave (
      input  req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
             mem_ack, mem_rdata, rsp_ready,
      output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             rsp_valid, rsp_data, rsp_rd, rsp_err
   );

   // Core plus memory environment driving the unit
   modport master (
      output req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
             mem_ack, mem_rdata, rsp_ready,
      input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             rsp_valid, rsp_data, rsp_rd, rsp_err
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables/data and load extraction/extension.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int BE_W  = XLEN / 8,
   parameter int OFF_W = $clog2(BE_W)
) (
   input  logic [1:0]       size,
   input  logic             is_unsigned,
   input  logic [OFF_W-1:0] off,
   input  logic [XLEN-1:0]  wdata,
   input  logic [XLEN-1:0]  rdata,
   output logic [BE_W-1:0]  be,
   output logic [XLEN-1:0]  wdata_lane,
   output logic [XLEN-1:0]  rdata_ext
);
   logic [XLEN-1:0] shifted_s;

   // Byte enables and lane-shifted store data
   always_comb begin
      be         = {BE_W{1'b1}};
      wdata_lane = wdata << {off, 3'b000};
      case (size)
         SZ_B:    be = BE_W'(1'b1) << off;
         SZ_H:    be = BE_W'(2'b11) << off;
         SZ_W:    be = BE_W'(4'hF) << off;
         default: be = {BE_W{1'b1}};
      endcase
   end

   // Load data: bring the addressed lane down, then sign- or zero-extend
   always_comb begin
      shifted_s = rdata >> {off, 3'b000};
      rdata_ext = shifted_s;
      case (size)
         SZ_B:    rdata_ext = is_unsigned ? XLEN'(shifted_s[7:0])  : XLEN'($signed(shifted_s[7:0]));
         SZ_H:    rdata_ext = is_unsigned ? XLEN'(shifted_s[15:0]) : XLEN'($signed(shifted_s[15:0]));
         SZ_W:    rdata_ext = is_unsigned ? XLEN'(shifted_s[31:0]) : XLEN'($signed(shifted_s[31:0]));
         default: rdata_ext = shifted_s;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: decode, memory handshake with timeout, held response.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic rst,
   lsu_if.slave bus
);
   localparam int BE_W  = XLEN / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("load_store_unit: XLEN must be 32 or 64");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("load_store_unit: TIMEOUT must be at least 1");
   end

   state_e           state_r, nxt_state_s;
   logic [CNT_W-1:0] cnt_r, nxt_cnt_s;
   logic [4:0]       rd_r, nxt_rd_s;
   logic             we_r, nxt_we_s;
   logic [1:0]       size_r, nxt_size_s;
   logic             uns_r, nxt_uns_s;
   logic [OFF_W-1:0] off_r, nxt_off_s;
   logic             mem_req_r, nxt_mem_req_s;
   logic             mem_we_r, nxt_mem_we_s;
   logic [XLEN-1:0]  mem_addr_r, nxt_mem_addr_s;
   logic [BE_W-1:0]  mem_be_r, nxt_mem_be_s;
   logic [XLEN-1:0]  mem_wdata_r, nxt_mem_wdata_s;
   logic             rsp_valid_r, nxt_rsp_valid_s;
   logic [XLEN-1:0]  rsp_data_r, nxt_rsp_data_s;
   logic [4:0]       rsp_rd_r, nxt_rsp_rd_s;
   logic [1:0]       rsp_err_r, nxt_rsp_err_s;

   logic [XLEN-1:0]  ea_s;
   logic             illegal_s, misalign_s;
   logic [1:0]       al_size_s;
   logic             al_uns_s;
   logic [OFF_W-1:0] al_off_s;
   logic [BE_W-1:0]  al_be_s;
   logic [XLEN-1:0]  al_wdata_s, al_rdata_s;

   // Request decode; the aligner sees the live request in IDLE and the latched one otherwise
   always_comb begin
      ea_s       = bus.req_base + bus.req_offset;
      illegal_s  = f3_is_illegal(bus.req_funct3, bus.req_we, XLEN);
      misalign_s = is_misaligned(bus.req_funct3[1:0], ea_s[2:0]);
      if (state_r == IDLE) begin
         al_size_s = bus.req_funct3[1:0];
         al_uns_s  = bus.req_funct3[2];
         al_off_s  = ea_s[OFF_W-1:0];
      end else begin
         al_size_s = size_r;
         al_uns_s  = uns_r;
         al_off_s  = off_r;
      end
   end

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .size        (al_size_s),
      .is_unsigned (al_uns_s),
      .off         (al_off_s),
      .wdata       (bus.req_wdata),
      .rdata       (bus.mem_rdata),
      .be          (al_be_s),
      .wdata_lane  (al_wdata_s),
      .rdata_ext   (al_rdata_s)
   );

   // Next-state and next registered-output logic
   always_comb begin
      nxt_state_s     = state_r;
      nxt_cnt_s       = cnt_r;
      nxt_rd_s        = rd_r;
      nxt_we_s        = we_r;
      nxt_size_s      = size_r;
      nxt_uns_s       = uns_r;
      nxt_off_s       = off_r;
      nxt_mem_req_s   = mem_req_r;
      nxt_mem_we_s    = mem_we_r;
      nxt_mem_addr_s  = mem_addr_r;
      nxt_mem_be_s    = mem_be_r;
      nxt_mem_wdata_s = mem_wdata_r;
      nxt_rsp_valid_s = rsp_valid_r;
      nxt_rsp_data_s  = rsp_data_r;
      nxt_rsp_rd_s    = rsp_rd_r;
      nxt_rsp_err_s   = rsp_err_r;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               nxt_rd_s   = bus.req_rd;
               nxt_we_s   = bus.req_we;
               nxt_size_s = bus.req_funct3[1:0];
               nxt_uns_s  = bus.req_funct3[2];
               nxt_off_s  = ea_s[OFF_W-1:0];
               if (illegal_s || misalign_s) begin
                  // Illegal funct3 outranks misalignment; no memory access is made
                  nxt_state_s     = RESP;
                  nxt_rsp_valid_s = 1'b1;
                  nxt_rsp_data_s  = {XLEN{1'b0}};
                  nxt_rsp_rd_s    = bus.req_rd;
                  nxt_rsp_err_s   = illegal_s ? ERR_ILLEGAL : ERR_MISALIGN;
               end else begin
                  nxt_state_s     = ACCESS;
                  nxt_cnt_s       = {CNT_W{1'b0}};
                  nxt_mem_req_s   = 1'b1;
                  nxt_mem_we_s    = bus.req_we;
                  nxt_mem_addr_s  = {ea_s[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                  nxt_mem_be_s    = al_be_s;
                  nxt_mem_wdata_s = al_wdata_s;
               end
            end else begin
               nxt_state_s = IDLE;
            end
         end
         ACCESS: begin
            if (bus.mem_ack) begin
               nxt_state_s     = RESP;
               nxt_mem_req_s   = 1'b0;
               nxt_rsp_valid_s = 1'b1;
               nxt_rsp_data_s  = we_r ? {XLEN{1'b0}} : al_rdata_s;
               nxt_rsp_rd_s    = rd_r;
               nxt_rsp_err_s   = ERR_OK;
            end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
               nxt_state_s     = RESP;
               nxt_mem_req_s   = 1'b0;
               nxt_rsp_valid_s = 1'b1;
               nxt_rsp_data_s  = {XLEN{1'b0}};
               nxt_rsp_rd_s    = rd_r;
               nxt_rsp_err_s   = ERR_TIMEOUT;
            end else begin
               nxt_cnt_s = cnt_r + CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               nxt_state_s     = IDLE;
               nxt_rsp_valid_s = 1'b0;
            end else begin
               nxt_state_s = RESP;
            end
         end
         default: begin
            nxt_state_s     = IDLE;
            nxt_mem_req_s   = 1'b0;
            nxt_rsp_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         rd_r        <= 5'd0;
         we_r        <= 1'b0;
         size_r      <= 2'd0;
         uns_r       <= 1'b0;
         off_r       <= {OFF_W{1'b0}};
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {XLEN{1'b0}};
         mem_be_r    <= {BE_W{1'b0}};
         mem_wdata_r <= {XLEN{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {XLEN{1'b0}};
         rsp_rd_r    <= 5'd0;
         rsp_err_r   <= 2'b00;
      end else begin
         state_r     <= nxt_state_s;
         cnt_r       <= nxt_cnt_s;
         rd_r        <= nxt_rd_s;
         we_r        <= nxt_we_s;
         size_r      <= nxt_size_s;
         uns_r       <= nxt_uns_s;
         off_r       <= nxt_off_s;
         mem_req_r   <= nxt_mem_req_s;
         mem_we_r    <= nxt_mem_we_s;
         mem_addr_r  <= nxt_mem_addr_s;
         mem_be_r    <= nxt_mem_be_s;
         mem_wdata_r <= nxt_mem_wdata_s;
         rsp_valid_r <= nxt_rsp_valid_s;
         rsp_data_r  <= nxt_rsp_data_s;
         rsp_rd_r    <= nxt_rsp_rd_s;
         rsp_err_r   <= nxt_rsp_err_s;
      end
   end

   assign bus.req_ready = rst && (state_r == IDLE);
   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_be    = mem_be_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_rd    = rsp_rd_r;
   assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit (XLEN=32, TIMEOUT=16).
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   lsu_if #(.XLEN(32)) bus ();

   load_store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; it must be accepted immediately
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] wdata, input logic [4:0] rd);
      bus.req_we = we; bus.req_funct3 = f3; bus.req_base = base;
      bus.req_offset = off; bus.req_wdata = wdata; bus.req_rd = rd; bus.req_valid = 1'b1;
      vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL issue_ready: got %b want 1", bus.req_ready); end
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
      vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
      vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
      vectors++; if (bus.mem_be !== 4'b0000) begin miscompares++; $display("FAIL rst_mem_be: got %b want 0000", bus.mem_be); end
      vectors++; if (bus.rsp_err !== 2'b00 || bus.rsp_data !== 32'h0) begin miscompares++; $display("FAIL rst_rsp: got err %b data %h want 00/0", bus.rsp_err, bus.rsp_data); end
      rst = 1'b1;
      #1;
      vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
   endtask

   task automatic test_lw();
      issue(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5);
      vectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL lw_req: got req %b we %b want 1/0", bus.mem_req, bus.mem_we); end
      vectors++; if (bus.mem_addr !== 32'h104) begin miscompares++; $display("FAIL lw_addr: got %h want 00000104", bus.mem_addr); end
      vectors++; if (bus.mem_be !== 4'b1111) begin miscompares++; $display("FAIL lw_be: got %b want 1111", bus.mem_be); end
      vectors++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lw_busy: got ready %b valid %b want 0/0", bus.req_ready, bus.rsp_valid); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      tick();
      bus.mem_ack = 1'b0;
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL lw_rsp_valid: got valid %b mem_req %b want 1/0", bus.rsp_valid, bus.mem_req); end
      vectors++; if (bus.rsp_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data: got %h want deadbeef", bus.rsp_data); end
      vectors++; if (bus.rsp_err !== 2'b00 || bus.rsp_rd !== 5'd5) begin miscompares++; $display("FAIL lw_err_rd: got err %b rd %0d want 00/5", bus.rsp_err, bus.rsp_rd); end
      tick();
      vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL lw_done: got valid %b ready %b want 0/1", bus.rsp_valid, bus.req_ready); end
   endtask

   task automatic test_lb_lbu();
      logic [2:0]  f3   [2] = '{3'b000, 3'b100};
      logic [31:0] base [2] = '{32'h104, 32'h100};
      logic [31:0] offs [2] = '{32'hFFFF_FFFF, 32'h3};
      logic [31:0] exp  [2] = '{32'hFFFF_FF80, 32'h0000_0080};
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, f3[i], base[i], offs[i], 32'h0, 5'd7);
         vectors++; if (bus.mem_addr !== 32'h100 || bus.mem_be !== 4'b1000) begin miscompares++; $display("FAIL lb%0d_addr_be: got %h/%b want 00000100/1000", i, bus.mem_addr, bus.mem_be); end
         bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_0000;
         tick();
         bus.mem_ack = 1'b0;
         vectors++; if (bus.rsp_data !== exp[i] || bus.rsp_err !== 2'b00) begin miscompares++; $display("FAIL lb%0d_data: got %h err %b want %h err 00", i, bus.rsp_data, bus.rsp_err, exp[i]); end
         tick();
      end
   endtask

   task automatic test_stores();
      issue(1'b1, 3'b001, 32'h200, 32'h2, 32'h1234ABCD, 5'd3);
      vectors++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200) begin miscompares++; $display("FAIL sh_we_addr: got %b/%h want 1/00000200", bus.mem_we, bus.mem_addr); end
      vectors++; if (bus.mem_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b want 1100", bus.mem_be); end
      vectors++; if (bus.mem_wdata[31:16] !== 16'hABCD) begin miscompares++; $display("FAIL sh_wdata: got %h want abcd", bus.mem_wdata[31:16]); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
      tick();
      bus.mem_ack = 1'b0;
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 2'b00) begin miscompares++; $display("FAIL sh_rsp: got v %b data %h err %b want 1/0/00", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
      tick();
      issue(1'b1, 3'b000, 32'h500, 32'h1, 32'h1234_56EF, 5'd4);
      vectors++; if (bus.mem_be !== 4'b0010 || bus.mem_wdata[15:8] !== 8'hEF) begin miscompares++; $display("FAIL sb_lane: got be %b byte %h want 0010/ef", bus.mem_be, bus.mem_wdata[15:8]); end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_errors();
      logic [2:0]  f3   [4] = '{3'b010, 3'b111, 3'b100, 3'b011};
      logic        we   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] base [4] = '{32'h101, 32'h100, 32'h100, 32'h101};
      logic [1:0]  exp  [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
      for (int i = 0; i < 4; i++) begin
         issue(we[i], f3[i], base[i], 32'h0, 32'hFFFF_FFFF, 5'd9);
         vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== exp[i]) begin miscompares++; $display("FAIL err%0d_code: got v %b err %b want 1/%b", i, bus.rsp_valid, bus.rsp_err, exp[i]); end
         vectors++; if (bus.mem_req !== 1'b0 || bus.rsp_data !== 32'h0) begin miscompares++; $display("FAIL err%0d_nomem: got mem_req %b data %h want 0/0", i, bus.mem_req, bus.rsp_data); end
         tick();
         vectors++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL err%0d_after: got mem_req %b ready %b want 0/1", i, bus.mem_req, bus.req_ready); end
      end
   endtask

   task automatic test_stall();
      issue(1'b0, 3'b001, 32'h100, 32'h6, 32'h0, 5'd11);
      for (int c = 0; c < 5; c++) begin
         vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_be !== 4'b1100) begin miscompares++; $display("FAIL stall%0d_hold: got req %b addr %h be %b want 1/00000104/1100", c, bus.mem_req, bus.mem_addr, bus.mem_be); end
         tick();
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8001_0000;
      tick();
      bus.mem_ack = 1'b0;
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hFFFF_8001) begin miscompares++; $display("FAIL stall_data: got v %b data %h want 1/ffff8001", bus.rsp_valid, bus.rsp_data); end
      tick();
   endtask

   task automatic test_timeout();
      issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd12);
      for (int c = 0; c < 16; c++) begin
         vectors++; if (bus.mem_req !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL to_cycle%0d: got req %b valid %b want 1/0", c, bus.mem_req, bus.rsp_valid); end
         tick();
      end
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 2'b11 || bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL to_rsp: got v %b err %b mem_req %b want 1/11/0", bus.rsp_valid, bus.rsp_err, bus.mem_req); end
      vectors++; if (bus.rsp_data !== 32'h0 || bus.rsp_rd !== 5'd12) begin miscompares++; $display("FAIL to_data: got %h rd %0d want 0/12", bus.rsp_data, bus.rsp_rd); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_AAAA;
      tick();
      vectors++; if (bus.mem_req !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL to_late_ack: got req %b v %b ready %b want 0/0/1", bus.mem_req, bus.rsp_valid, bus.req_ready); end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 5'd13);
      vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rm_access: got %b want 1", bus.mem_req); end
      rst = 1'b0;
      tick();
      vectors++; if (bus.mem_req !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_abandon: got req %b v %b ready %b want 0/0/0", bus.mem_req, bus.rsp_valid, bus.req_ready); end
      rst = 1'b1;
      tick();
      vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_release: got v %b ready %b want 0/1", bus.rsp_valid, bus.req_ready); end
      issue(1'b0, 3'b010, 32'h400, 32'h8, 32'h0, 5'd14);
      vectors++; if (bus.mem_addr !== 32'h408) begin miscompares++; $display("FAIL rm_fresh_addr: got %h want 00000408", bus.mem_addr); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0123_4567;
      tick();
      bus.mem_ack = 1'b0;
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0123_4567 || bus.rsp_rd !== 5'd14) begin miscompares++; $display("FAIL rm_fresh_rsp: got v %b data %h rd %0d want 1/01234567/14", bus.rsp_valid, bus.rsp_data, bus.rsp_rd); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.rsp_ready = 1'b0;
      issue(1'b0, 3'b100, 32'h500, 32'h1, 32'h0, 5'd21);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_AB00;
      tick();
      bus.mem_ack = 1'b0;
      bus.req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_00AB || bus.rsp_rd !== 5'd21 || bus.rsp_err !== 2'b00) begin miscompares++; $display("FAIL bp%0d_hold: got v %b data %h rd %0d err %b want 1/000000ab/21/00", c, bus.rsp_valid, bus.rsp_data, bus.rsp_rd, bus.rsp_err); end
         vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp%0d_ready: got %b want 0", c, bus.req_ready); end
         tick();
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_still: got %b want 1", bus.rsp_valid); end
      tick();
      vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL bp_release: got v %b ready %b req %b want 0/1/0", bus.rsp_valid, bus.req_ready, bus.mem_req); end
   endtask

   initial begin
      rst = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
      bus.req_base = 32'h0; bus.req_offset = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.rsp_ready = 1'b1;
      test_reset();
      test_lw();
      test_lb_lbu();
      test_stores();
      test_errors();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
